// File: rtl/filtro_janela.sv
// rtl/filtro_janela.sv - 8-tap sliding window with row-edge replication
// Feeds the half-sample interpolation filter; one window per accepted sample after a 4-sample fill.
module filtro_janela #(
  parameter int DATA_WIDTH = 8,
  parameter int ROW_LEN    = 64
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic signed [DATA_WIDTH+1:0] in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic signed [DATA_WIDTH+1:0] out0,
  output logic signed [DATA_WIDTH+1:0] out1,
  output logic signed [DATA_WIDTH+1:0] out2,
  output logic signed [DATA_WIDTH+1:0] out3,
  output logic signed [DATA_WIDTH+1:0] out4,
  output logic signed [DATA_WIDTH+1:0] out5,
  output logic signed [DATA_WIDTH+1:0] out6,
  output logic signed [DATA_WIDTH+1:0] out7,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         out_first,
  output logic                         out_last
);

  localparam int SW = DATA_WIDTH + 2;
  localparam int CW = $clog2(ROW_LEN);

  typedef enum logic [1:0] {FILL, RUN, FLUSH} state_t;

  state_t                r_state;
  state_t                w_next;
  logic signed [SW-1:0]  r_tap [8];
  logic [CW-1:0]         r_icnt;
  logic [1:0]            r_fcnt;
  logic                  r_valid;
  logic                  r_first;
  logic                  r_last;

  logic                  w_adv;
  logic                  w_acc;
  logic                  w_last_in;
  logic                  w_push;
  logic                  w_load;
  logic                  w_emit;
  logic signed [SW-1:0]  w_din;

  assign w_adv     = !r_valid || out_ready;
  assign in_ready  = rst_n && (r_state != FLUSH) && w_adv;
  assign w_acc     = in_valid && in_ready;
  assign w_last_in = (r_icnt == CW'(ROW_LEN - 1));

  // FLUSH replays the last sample so the right edge is replicated without new input
  assign w_push = (r_state == FLUSH) ? w_adv : w_acc;
  assign w_din  = (r_state == FLUSH) ? r_tap[7] : in_data;
  assign w_load = w_acc && (r_state == FILL) && (r_icnt == '0);
  assign w_emit = w_push && ((r_state != FILL) || (r_icnt == CW'(4)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= FILL;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      FILL:    if (w_acc && (r_icnt == CW'(4))) w_next = w_last_in ? FLUSH : RUN;
      RUN:     if (w_acc && w_last_in) w_next = FLUSH;
      FLUSH:   if (w_adv && (r_fcnt == 2'd3)) w_next = FILL;
      default: w_next = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) r_tap[i] <= '0;
      r_icnt  <= '0;
      r_fcnt  <= '0;
      r_valid <= 1'b0;
      r_first <= 1'b0;
      r_last  <= 1'b0;
    end else begin
      if (w_adv) begin
        r_valid <= w_emit;
        r_first <= w_emit && (r_state == FILL);
        r_last  <= w_emit && (r_state == FLUSH) && (r_fcnt == 2'd3);
        if (w_push) begin
          for (int i = 0; i < 7; i++) r_tap[i] <= w_load ? w_din : r_tap[i+1];
          r_tap[7] <= w_din;
        end
      end
      if (w_acc) r_icnt <= w_last_in ? '0 : r_icnt + CW'(1);
      if ((r_state == FLUSH) && w_adv) r_fcnt <= r_fcnt + 2'd1;
    end
  end

  assign out0      = r_tap[0];
  assign out1      = r_tap[1];
  assign out2      = r_tap[2];
  assign out3      = r_tap[3];
  assign out4      = r_tap[4];
  assign out5      = r_tap[5];
  assign out6      = r_tap[6];
  assign out7      = r_tap[7];
  assign out_valid = r_valid;
  assign out_first = r_first;
  assign out_last  = r_last;

endmodule

// File: tb/tb_filtro_janela.sv
// tb/tb_filtro_janela.sv - table vectors plus scoreboarded streams for filtro_janela
module tb_filtro_janela;
  localparam int DW = 8;
  localparam int N  = 8;
  localparam int SW = DW + 2;

  logic clk = 1'b0;
  logic rst_n;
  logic signed [SW-1:0] in_data;
  logic in_valid, in_ready, out_valid, out_ready, out_first, out_last;
  logic signed [SW-1:0] out0, out1, out2, out3, out4, out5, out6, out7;

  filtro_janela #(.DATA_WIDTH(DW), .ROW_LEN(N)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out0(out0), .out1(out1), .out2(out2), .out3(out3), .out4(out4), .out5(out5),
    .out6(out6), .out7(out7), .out_valid(out_valid), .out_ready(out_ready),
    .out_first(out_first), .out_last(out_last)
  );

  always #5 clk = ~clk;

  typedef logic [7:0][SW-1:0] taps_t;
  typedef struct packed { taps_t t; logic first; logic last; } win_t;
  typedef struct { logic iv; int din; logic ev; logic ef; logic el; logic eir; taps_t ew; } vec_t;

  win_t q_exp[$];
  int   q_in[$];
  vec_t tbl[$];
  int   n_chk = 0;
  int   n_pass = 0;

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic taps_t mk(input int a0, a1, a2, a3, a4, a5, a6, a7);
    taps_t r;
    r[0] = SW'(a0); r[1] = SW'(a1); r[2] = SW'(a2); r[3] = SW'(a3);
    r[4] = SW'(a4); r[5] = SW'(a5); r[6] = SW'(a6); r[7] = SW'(a7);
    return r;
  endfunction

  function automatic win_t cur_win();
    win_t r;
    r.t     = {out7, out6, out5, out4, out3, out2, out1, out0};
    r.first = out_first;
    r.last  = out_last;
    return r;
  endfunction

  task automatic addv(input logic iv, input int din, input logic ev, input logic ef,
                      input logic el, input logic eir, input taps_t ew);
    vec_t v;
    v.iv = iv; v.din = din; v.ev = ev; v.ef = ef; v.el = el; v.eir = eir; v.ew = ew;
    tbl.push_back(v);
  endtask

  // Reference: window x tap k is s[clamp(x-3+k)], first/last mark the row ends
  task automatic add_row(input int kind, input int base);
    int s[N];
    for (int i = 0; i < N; i++) begin
      case (kind)
        0:       s[i] = base * (i + 1);
        1:       s[i] = (i % 2 == 1) ? 511 : -512;
        default: s[i] = int'($urandom_range(0, 1023)) - 512;
      endcase
      q_in.push_back(s[i]);
    end
    for (int x = 0; x < N; x++) begin
      win_t w;
      for (int k = 0; k < 8; k++) begin
        int j;
        j = x - 3 + k;
        if (j < 0) j = 0;
        if (j > N - 1) j = N - 1;
        w.t[k] = SW'(s[j]);
      end
      w.first = (x == 0);
      w.last  = (x == N - 1);
      q_exp.push_back(w);
    end
  endtask

  // mode 0: full rate, 1: in_valid every other cycle, 2: 3-cycle stall at window x=2, 3: random
  task automatic run_stream(input int mode);
    int   cyc, stall, cons;
    logic held;
    win_t hw, cw;
    cyc = 0; stall = 0; cons = 0; held = 1'b0;
    while (q_exp.size() > 0 && cyc < 3000) begin
      @(negedge clk);
      in_valid  = (q_in.size() > 0) && ((mode == 1) ? (cyc % 2 == 0) :
                  (mode == 3) ? ($urandom_range(0, 2) != 0) : 1'b1);
      in_data   = (q_in.size() > 0) ? SW'(q_in[0]) : '0;
      out_ready = (mode == 3) ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (mode == 2 && out_valid && cons == 2 && stall < 3) begin
        out_ready = 1'b0;
        stall++;
      end
      #1;
      cw = cur_win();
      if (held) begin
        chk("bp hold window", cw, hw);
        chk("bp hold valid", out_valid, 1);
      end
      held = 1'b0;
      if (out_valid && !out_ready) begin
        chk("bp in_ready", in_ready, 0);
        held = 1'b1;
        hw = cw;
      end
      if (out_valid && out_ready) begin
        chk($sformatf("m%0d window %0d", mode, cons), cw, q_exp.pop_front());
        cons++;
      end
      if (in_valid && in_ready) void'(q_in.pop_front());
      cyc++;
      @(posedge clk);
    end
    chk($sformatf("m%0d windows left", mode), q_exp.size(), 0);
    chk($sformatf("m%0d samples left", mode), q_in.size(), 0);
    if (mode == 2) chk("bp stall cycles", stall, 3);
    q_exp.delete();
    q_in.delete();
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset out_valid", out_valid, 0);
    chk("reset first", out_first, 0);
    chk("reset last", out_last, 0);
    chk("reset in_ready", in_ready, 0);
    chk("reset taps", cur_win().t, 0);
    @(negedge clk) rst_n = 1'b1;

    addv(1, 10, 0, 0, 0, 1, '0);
    addv(1, 20, 0, 0, 0, 1, '0);
    addv(1, 30, 0, 0, 0, 1, '0);
    addv(1, 40, 0, 0, 0, 1, '0);
    addv(1, 50, 1, 1, 0, 1, mk(10, 10, 10, 10, 20, 30, 40, 50));
    addv(1, 60, 1, 0, 0, 1, mk(10, 10, 10, 20, 30, 40, 50, 60));
    addv(1, 70, 1, 0, 0, 1, mk(10, 10, 20, 30, 40, 50, 60, 70));
    addv(1, 80, 1, 0, 0, 0, mk(10, 20, 30, 40, 50, 60, 70, 80));
    addv(1, 999, 1, 0, 0, 0, mk(20, 30, 40, 50, 60, 70, 80, 80));
    addv(1, 999, 1, 0, 0, 0, mk(30, 40, 50, 60, 70, 80, 80, 80));
    addv(1, 999, 1, 0, 0, 0, mk(40, 50, 60, 70, 80, 80, 80, 80));
    addv(1, 999, 1, 0, 1, 1, mk(50, 60, 70, 80, 80, 80, 80, 80));
    addv(0, 0, 0, 0, 0, 1, '0);
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      in_valid  = tbl[i].iv;
      in_data   = SW'(tbl[i].din);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk($sformatf("t1[%0d] out_valid", i), out_valid, tbl[i].ev);
      chk($sformatf("t1[%0d] first", i), out_first, tbl[i].ef);
      chk($sformatf("t1[%0d] last", i), out_last, tbl[i].el);
      chk($sformatf("t1[%0d] in_ready", i), in_ready, tbl[i].eir);
      if (tbl[i].ev) chk($sformatf("t1[%0d] taps", i), cur_win().t, tbl[i].ew);
    end

    add_row(0, 10);
    run_stream(2);
    add_row(0, 10);
    add_row(0, 100);
    run_stream(0);
    add_row(1, 0);
    add_row(1, 0);
    run_stream(0);
    add_row(0, 10);
    run_stream(1);
    for (int r = 0; r < 4; r++) add_row(2, 0);
    run_stream(3);

    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      in_valid  = 1'b1;
      in_data   = SW'(10 * (i + 1));
      out_ready = 1'b1;
    end
    @(negedge clk) in_valid = 1'b0;
    @(posedge clk);
    #2;
    chk("pre-reset flush valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("mid-flush reset valid", out_valid, 0);
    chk("mid-flush reset taps", cur_win().t, 0);
    chk("mid-flush reset first", out_first, 0);
    chk("mid-flush reset last", out_last, 0);
    chk("mid-flush reset in_ready", in_ready, 0);
    @(negedge clk) rst_n = 1'b1;
    add_row(0, 7);
    run_stream(0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
